// File: rtl/adder_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : adder_rr_scheduler
// Description : Round-robin scheduler sharing one pipelined, chunked
//               ripple-carry adder between N requesters. Each operation
//               carries its requester ID down the pipeline; the last stage
//               register is the result port (valid/ready, full stall).
// Option      : ADDER_RR_SCHEDULER_STATS_EN adds op_count and busy outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_rr_scheduler #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 4,
    parameter int N       = 4,
    localparam int IDW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       req_valid,
    output logic [N-1:0]       req_ready,
    input  logic [N*WIDTH-1:0] req_a,
    input  logic [N*WIDTH-1:0] req_b,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WIDTH-1:0]   res_sum,
    output logic               res_carry,
    output logic [IDW-1:0]     res_id
`ifdef ADDER_RR_SCHEDULER_STATS_EN
    ,
    output logic [31:0]        op_count,
    output logic               busy
`endif
);

    // Chunk width and operand width padded to a whole number of chunks.
    // Padding bits are zero, so bit WIDTH of the padded sum is the true carry.
    localparam int c_CHUNK_W = (WIDTH + LATENCY - 1) / LATENCY;
    localparam int c_PAD_W   = c_CHUNK_W * LATENCY;

    // Adds chunk s of a and b plus the incoming carry; returns {carry, sum}
    // where sum is sum_in with chunk s replaced.
    function automatic logic [c_PAD_W:0] f_add_chunk(
        input logic [c_PAD_W-1:0] a,
        input logic [c_PAD_W-1:0] b,
        input logic [c_PAD_W-1:0] sum_in,
        input logic               c_in,
        input int                 s
    );
        logic [c_CHUNK_W:0]   v_t;
        logic [c_PAD_W-1:0]   v_sum;
        v_t = {1'b0, a[s*c_CHUNK_W +: c_CHUNK_W]}
            + {1'b0, b[s*c_CHUNK_W +: c_CHUNK_W]}
            + {{c_CHUNK_W{1'b0}}, c_in};
        v_sum = sum_in;
        v_sum[s*c_CHUNK_W +: c_CHUNK_W] = v_t[c_CHUNK_W-1:0];
        return {v_t[c_CHUNK_W], v_sum};
    endfunction

    logic [IDW-1:0]     r_ptr;
    logic [IDW-1:0]     w_grant;
    logic [IDW-1:0]     w_ptr_nxt;
    logic               w_any;
    logic               w_adv;
    logic               w_hs;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;
    logic [c_PAD_W-1:0] w_pad_a;
    logic [c_PAD_W-1:0] w_pad_b;

    // Stage registers: forwarded operands, partial sum, chunk carry, ID, valid.
    logic [c_PAD_W-1:0] r_a   [LATENCY];
    logic [c_PAD_W-1:0] r_b   [LATENCY];
    logic [c_PAD_W-1:0] r_sum [LATENCY];
    logic               r_c   [LATENCY];
    logic [IDW-1:0]     r_id  [LATENCY];
    logic [LATENCY-1:0] r_v;
    logic [c_PAD_W:0]   w_stage [LATENCY];

    // The whole pipeline moves only when the result slot is free or draining.
    assign w_adv = !r_v[LATENCY-1] || res_ready;
    assign w_hs  = w_any && w_adv;

    // Round-robin pick: lowest requester at or above ptr, else lowest below it.
    always_comb begin
        logic             v_hi_found;
        logic             v_lo_found;
        logic [IDW-1:0]   v_hi;
        logic [IDW-1:0]   v_lo;
        v_hi_found = 1'b0;
        v_lo_found = 1'b0;
        v_hi       = '0;
        v_lo       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                if (IDW'(k) >= r_ptr) begin
                    v_hi_found = 1'b1;
                    v_hi       = IDW'(k);
                end else begin
                    v_lo_found = 1'b1;
                    v_lo       = IDW'(k);
                end
            end
        end
        w_any   = v_hi_found || v_lo_found;
        w_grant = v_hi_found ? v_hi : v_lo;
    end

    // Operand mux, one-hot ready and wrap-around pointer successor.
    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        req_ready = '0;
        for (int k = 0; k < N; k++) begin
            if (IDW'(k) == w_grant) begin
                w_sel_a      = req_a[k*WIDTH +: WIDTH];
                w_sel_b      = req_b[k*WIDTH +: WIDTH];
                req_ready[k] = w_hs;
            end
        end
        w_ptr_nxt = (w_grant == IDW'(N - 1)) ? '0 : w_grant + 1'b1;
    end

    assign w_pad_a = c_PAD_W'(w_sel_a);
    assign w_pad_b = c_PAD_W'(w_sel_b);

    // Per-stage chunk adders; stage 0 starts from a zero sum and no carry.
    always_comb begin
        w_stage[0] = f_add_chunk(w_pad_a, w_pad_b, '0, 1'b0, 0);
        for (int s = 1; s < LATENCY; s++) begin
            w_stage[s] = f_add_chunk(r_a[s-1], r_b[s-1], r_sum[s-1], r_c[s-1], s);
        end
    end

    // Arbitration pointer advances past the winner on each handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_hs) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Pipeline registers; every stage holds together when the output stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                r_a[s]   <= '0;
                r_b[s]   <= '0;
                r_sum[s] <= '0;
                r_c[s]   <= 1'b0;
                r_id[s]  <= '0;
            end
        end else if (w_adv) begin
            r_v[0]               <= w_any;
            r_a[0]               <= w_pad_a;
            r_b[0]               <= w_pad_b;
            r_id[0]              <= w_grant;
            {r_c[0], r_sum[0]}   <= w_stage[0];
            for (int s = 1; s < LATENCY; s++) begin
                r_v[s]             <= r_v[s-1];
                r_a[s]             <= r_a[s-1];
                r_b[s]             <= r_b[s-1];
                r_id[s]            <= r_id[s-1];
                {r_c[s], r_sum[s]} <= w_stage[s];
            end
        end
    end

    assign res_valid = r_v[LATENCY-1];
    assign res_sum   = r_sum[LATENCY-1][WIDTH-1:0];
    assign res_id    = r_id[LATENCY-1];

    // When chunks tile WIDTH exactly the carry is the last chunk carry;
    // otherwise it lands in the first padding bit of the sum.
    generate
        if (c_PAD_W == WIDTH) begin : g_carry_exact
            assign res_carry = r_c[LATENCY-1];
        end else begin : g_carry_pad
            assign res_carry = r_sum[LATENCY-1][WIDTH];
        end
    endgenerate

`ifdef ADDER_RR_SCHEDULER_STATS_EN
    logic [31:0] r_op_count;

    // Count accepted requests; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (w_hs) begin
            r_op_count <= r_op_count + 32'd1;
        end
    end

    assign op_count = r_op_count;
    assign busy     = |r_v;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_rr_scheduler
// Description : Self-checking bench for adder_rr_scheduler. A queue-based
//               model (acceptance order, per-op age in advancing cycles)
//               predicts outputs each cycle; directed literals pin it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_rr_scheduler;

    localparam int W  = 8;
    localparam int L  = 4;
    localparam int NR = 4;
    localparam int W2 = 7;
    localparam int L2 = 3;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*W-1:0]   req_a;
    logic [NR*W-1:0]   req_b;
    logic              res_valid;
    logic              res_ready;
    logic [W-1:0]      res_sum;
    logic              res_carry;
    logic [1:0]        res_id;

    logic [0:0]        req_valid2;
    logic [0:0]        req_ready2;
    logic [W2-1:0]     req_a2;
    logic [W2-1:0]     req_b2;
    logic              res_valid2;
    logic              res_ready2;
    logic [W2-1:0]     res_sum2;
    logic              res_carry2;
    logic [0:0]        res_id2;
`ifdef ADDER_RR_SCHEDULER_STATS_EN
    logic [31:0]       op_count;
    logic              busy;
    logic [31:0]       op_count2;
    logic              busy2;
`endif

    int checks = 0;
    int errors = 0;

    adder_rr_scheduler #(.WIDTH(W), .LATENCY(L), .N(NR)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_carry(res_carry), .res_id(res_id)
`ifdef ADDER_RR_SCHEDULER_STATS_EN
        , .op_count(op_count), .busy(busy)
`endif
    );

    adder_rr_scheduler #(.WIDTH(W2), .LATENCY(L2), .N(1)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid2), .req_ready(req_ready2),
        .req_a(req_a2), .req_b(req_b2),
        .res_valid(res_valid2), .res_ready(res_ready2),
        .res_sum(res_sum2), .res_carry(res_carry2), .res_id(res_id2)
`ifdef ADDER_RR_SCHEDULER_STATS_EN
        , .op_count(op_count2), .busy(busy2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [8:0] total;
        int         id;
        int         age;
    } ent_t;

    ent_t q1[$];
    ent_t q2[$];
    int   ptr1  = 0;
    int   acc1  = 0;
    int   acc2  = 0;
    int   count2 = 0;

    // Model of the 8-bit/4-stage/4-requester instance, evaluated mid-cycle.
    always @(negedge clk) begin
        bit         mv;
        bit         adv;
        bit         found;
        int         g;
        logic [3:0] er;
        ent_t       e;
        if (!rst_n) begin
            q1.delete();
            ptr1 = 0;
            acc1 = 0;
        end else begin
            mv = (q1.size() > 0) && (q1[0].age == L);
            chk("m1_res_valid", res_valid, mv);
            if (mv) begin
                chk("m1_res_sum", res_sum, q1[0].total[7:0]);
                chk("m1_res_carry", res_carry, q1[0].total[8]);
                chk("m1_res_id", res_id, q1[0].id);
            end
            adv   = !mv || res_ready;
            found = 0;
            g     = 0;
            for (int i = 0; i < NR; i++) begin
                int k;
                k = (ptr1 + i) % NR;
                if (!found && req_valid[k]) begin
                    found = 1;
                    g     = k;
                end
            end
            er = (found && adv) ? 4'(1 << g) : 4'b0000;
            chk("m1_req_ready", req_ready, er);
`ifdef ADDER_RR_SCHEDULER_STATS_EN
            chk("m1_op_count", op_count, acc1);
            chk("m1_busy", busy, q1.size() > 0);
`endif
            if (adv) begin
                if (mv) void'(q1.pop_front());
                for (int j = 0; j < q1.size(); j++) q1[j].age++;
                if (found) begin
                    e.total = {1'b0, req_a[g*W +: W]} + {1'b0, req_b[g*W +: W]};
                    e.id    = g;
                    e.age   = 1;
                    q1.push_back(e);
                    ptr1 = (g + 1) % NR;
                    acc1++;
                end
            end
        end
    end

    // Model of the 7-bit/3-stage single-requester instance.
    always @(negedge clk) begin
        bit   mv;
        bit   adv;
        ent_t e;
        if (!rst_n) begin
            q2.delete();
            acc2 = 0;
        end else begin
            mv = (q2.size() > 0) && (q2[0].age == L2);
            chk("m2_res_valid", res_valid2, mv);
            if (mv) begin
                chk("m2_res_sum", res_sum2, q2[0].total[6:0]);
                chk("m2_res_carry", res_carry2, q2[0].total[7]);
                chk("m2_res_id", res_id2, 0);
            end
            adv = !mv || res_ready2;
            chk("m2_req_ready", req_ready2, req_valid2[0] && adv);
`ifdef ADDER_RR_SCHEDULER_STATS_EN
            chk("m2_op_count", op_count2, acc2);
            chk("m2_busy", busy2, q2.size() > 0);
`endif
            if (adv) begin
                if (mv) void'(q2.pop_front());
                for (int j = 0; j < q2.size(); j++) q2[j].age++;
                if (req_valid2[0]) begin
                    e.total = {2'b00, req_a2} + {2'b00, req_b2};
                    e.id    = 0;
                    e.age   = 1;
                    q2.push_back(e);
                    acc2++;
                    count2++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_oh [5];
        int         cyc;
        exp_oh = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        rst_n = 0; req_valid = 0; req_a = 0; req_b = 0; res_ready = 1;
        req_valid2 = 0; req_a2 = 0; req_b2 = 0; res_ready2 = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_sum", res_sum, 0);
        chk("rst_res_carry", res_carry, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_valid2", res_valid2, 0);
        @(posedge clk); #1 rst_n = 1;

        // 0xFF + 0x01 from requester 0: sum 0, carry 1 after 4 cycles
        req_valid = 4'b0001; req_a[7:0] = 8'hFF; req_b[7:0] = 8'h01;
        @(negedge clk); chk("t1_req_ready", req_ready, 4'b0001);
        @(posedge clk); #1 req_valid = 0;
        for (int i = 0; i < L - 1; i++) begin
            @(negedge clk); chk("t1_early_valid", res_valid, 0);
            @(posedge clk);
        end
        @(negedge clk);
        chk("t1_valid", res_valid, 1);
        chk("t1_sum", res_sum, 8'h00);
        chk("t1_carry", res_carry, 1);
        chk("t1_id", res_id, 0);

        // requester 3 once, so the pointer wraps back to 0
        @(posedge clk); #1 req_valid = 4'b1000;
        @(negedge clk); chk("wrap_req_ready", req_ready, 4'b1000);
        @(posedge clk); #1 req_valid = 0;

        // all requesters valid: grants 0,1,2,3,0
        req_a = 32'hC0807F01; req_b = 32'h508001FE; req_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); chk("t2_grant", req_ready, exp_oh[i]);
            @(posedge clk); #1;
        end

        // output holds requester 1's result (0x7F+0x01) during a 3-cycle stall
        res_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_stall_ready", req_ready, 4'b0000);
            chk("t3_stall_valid", res_valid, 1);
            chk("t3_stall_sum", res_sum, 8'h80);
            chk("t3_stall_carry", res_carry, 0);
            chk("t3_stall_id", res_id, 1);
            @(posedge clk); #1;
        end
        res_ready = 1;
        @(negedge clk); chk("t3_resume_grant", req_ready, 4'b0010);
        repeat (6) @(posedge clk);
        #1 req_valid = 0;
        repeat (10) @(posedge clk);

        // reset with three operations in flight
        #1 req_valid = 4'hF;
        repeat (3) @(posedge clk);
        #1 req_valid = 0;
        @(posedge clk); #1;
        chk("t4_pre_valid", res_valid, 1);
        rst_n = 0;
        #1;
        chk("t4_rst_valid", res_valid, 0);
        chk("t4_rst_sum", res_sum, 0);
        chk("t4_rst_carry", res_carry, 0);
        chk("t4_rst_id", res_id, 0);
        @(posedge clk); #1 rst_n = 1; req_valid = 4'hF;
        @(negedge clk); chk("t4_first_grant", req_ready, 4'b0001);
        @(posedge clk); #1 req_valid = 0;
        for (int i = 0; i < L - 1; i++) begin
            @(negedge clk); chk("t4_no_stale", res_valid, 0);
            @(posedge clk);
        end
        @(negedge clk);
        chk("t4_valid", res_valid, 1);
        chk("t4_sum", res_sum, 8'hFF);
        chk("t4_id", res_id, 0);
        repeat (6) @(posedge clk);

        // 7-bit, 3-stage instance: 0x7F + 0x01 wraps to 0 with carry
        #1 req_valid2 = 1; req_a2 = 7'h7F; req_b2 = 7'h01;
        @(posedge clk); #1 req_valid2 = 0;
        repeat (L2 - 1) @(posedge clk);
        @(negedge clk);
        chk("t5_valid", res_valid2, 1);
        chk("t5_sum", res_sum2, 7'h00);
        chk("t5_carry", res_carry2, 1);
        @(posedge clk);

        // random operands and backpressure on the 7-bit instance
        count2 = 0;
        cyc    = 0;
        while (count2 < 1000 && cyc < 6000) begin
            @(posedge clk); #1;
            req_valid2 = ($urandom_range(0, 4) != 0);
            req_a2     = W2'($urandom);
            req_b2     = W2'($urandom);
            res_ready2 = ($urandom_range(0, 3) != 0);
            cyc++;
        end
        chk("t5_ops_done", count2 >= 1000, 1);
        @(posedge clk); #1 req_valid2 = 0; res_ready2 = 1;
        repeat (L2 + 3) @(posedge clk);
        @(negedge clk); chk("t5_drained", res_valid2, 0);

`ifdef ADDER_RR_SCHEDULER_STATS_EN
        @(posedge clk); #1 rst_n = 0;
        @(posedge clk); #1 rst_n = 1; req_valid = 4'hF;
        repeat (10) @(posedge clk);
        #1 req_valid = 0;
        chk("t6_busy_hi", busy, 1);
        chk("t6_op_count", op_count, 10);
        repeat (L + 2) @(posedge clk);
        @(negedge clk);
        chk("t6_busy_lo", busy, 0);
        chk("t6_op_count_hold", op_count, 10);
`endif

        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adder_rr_scheduler.md
Name: adder_rr_scheduler

Overview:
- Shares one internally pipelined, chunked ripple-carry adder between N requesters; round-robin arbitration, one issue per cycle.
- Carries each operation's requester ID through the adder pipeline and returns sum, carry and ID on a single result port with valid/ready backpressure.
- Sits between multiple counter/accumulator clients and the shared arithmetic resource.

Parameters:
- WIDTH, 8, operand/sum width in bits (>=1).
- LATENCY, 4, adder pipeline depth in cycles, 1..WIDTH; chunk width = ceil(WIDTH/LATENCY).
- N, 4, number of requesters (>=1); IDW = max(1, clog2(N)).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  N  per-requester operation valid.
- req_ready  out  N  per-requester accept; one-hot or zero.
- req_a  in  N*WIDTH  operand A, requester k at [k*WIDTH +: WIDTH].
- req_b  in  N*WIDTH  operand B, same packing.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_sum  out  WIDTH  (a+b) mod 2^WIDTH.
- res_carry  out  1  bit WIDTH of a+b.
- res_id  out  IDW  index of the requester that issued this result.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low, clk / rst_n.
- Reset: res_valid=0, res_sum=0, res_carry=0, res_id=0, all stage valid bits 0, rr pointer=0. Reset mid-operation discards all in-flight operations; no result is emitted for them.
- Pipeline: LATENCY stages. Stage s adds chunk s (operands + registered carry from stage s-1) and forwards the remaining operand chunks, partial sum, valid and ID. The last stage register is the result port.
- Global advance: adv = !res_valid || res_ready. When adv=0, every stage holds (full stall; no bubble compression).
- Arbitration: grant = first k with req_valid[k]=1, scanning ptr, ptr+1, ..., wrapping mod N. req_ready[grant] = adv; all other req_ready = 0. A handshake occurs on req_valid[k] && req_ready[k].
- On a handshake, ptr <= grant+1 mod N. With no handshake (no requests, or stalled), ptr is unchanged.
- Latency: an operation accepted at cycle t produces res_valid=1 at cycle t+LATENCY if no stall occurs. Each stall cycle adds one cycle.
- Throughput: 1 op/cycle while res_ready=1.
- Results leave in acceptance order. res_* are stable while res_valid && !res_ready.
- Last chunk may be narrower (WIDTH mod chunk). res_carry is the carry out of the last chunk.
- LATENCY=1 degenerates to a single registered full adder. N=1 always grants requester 0, and res_id=0.
- req_valid deasserting without a handshake is legal. req_* are sampled only on the handshake.

Optional Feature:
- Macro ADDER_RR_SCHEDULER_STATS_EN.
- Defined: adds output port op_count (32 bits), reset 0. It increments by 1 per accepted request and wraps from 2^32-1 to 0. It adds output port busy (1 bit), high when any stage valid bit is set.
- Undefined: neither port exists, and no counter logic is generated.

Test Plan:
- WIDTH=8, LATENCY=4: requester 0 issues a=0xFF, b=0x01 at t. Required at t+4: res_valid=1, res_sum=0x00, res_carry=1, res_id=0.
- All 4 requesters held valid with res_ready=1: grants cycle 0,1,2,3,0, one per cycle. Results return in order with matching res_id, one per cycle.
- res_ready=0 for 3 cycles while results are in flight: req_ready=0 throughout, res_* held stable. Once released, results resume with none lost or duplicated.
- rst_n asserted low with 3 operations in flight: outputs go to reset values immediately. After release, no stale res_valid appears and the first grant goes to requester 0.
- WIDTH=7, LATENCY=3 (chunks 3,3,1): random a/b for 1000 ops. res_sum/res_carry must equal the reference a+b.
- With ADDER_RR_SCHEDULER_STATS_EN: 10 accepted ops give op_count=10. busy=1 while any op is in flight and 0 once the pipeline drains.
